// File: rtl/spi_top.sv
// Single-frame SPI engine: config byte and tx bytes in over the host bus, one SPI
// frame as leader or follower, then the received bytes driven back on the bus.
module spi_top (
  input  logic     clk,
  input  logic     rst,
  input  logic     in,
  output logic     out,
  inout  wire [7:0] data,
  inout  wire      cs,
  inout  wire      ext_clk
);

  typedef enum logic [1:0] {
    CFG  = 2'b00,
    LOAD = 2'b01,
    XFER = 2'b10,
    DONE = 2'b11
  } state_t;

  state_t      state;
  logic        config_set;
  logic        data_en;
  logic [7:0]  cfg;
  logic        load_hi_done;
  logic [15:0] tx_sr;
  logic [15:0] rx_sr;
  logic        out_q;
  logic [7:0]  data_q;
  logic        cs_q;
  logic        clk_q;
  logic        cs_oe;
  logic        clk_oe;
  logic [3:0]  tmr;
  logic [5:0]  ph;
  logic [4:0]  bits;
  logic        hold;
  logic        cs_s1, cs_s2, cs_s3;
  logic        ck_s1, ck_s2, ck_s3;

  logic        mode, len, cpol, cpha;
  logic [3:0]  div;
  assign {mode, len, cpol, cpha, div} = cfg;

  logic [5:0]  two_n;
  logic [5:0]  ph_next;
  logic [4:0]  nbits;
  logic        tick, active, ck_rise, ck_fall, cs_rise;
  logic        lead_ev, trail_ev, sample_ev, shift_ev, xfer_done;

  // Leader edges come from the div timer; follower edges from the synchronised pins.
  always_comb begin
    two_n     = len ? 6'd32 : 6'd16;
    nbits     = len ? 5'd16 : 5'd8;
    ph_next   = ph + 6'd1;
    tick      = (state == XFER) && mode && (tmr == div - 4'd1);
    active    = !cs_s2;
    ck_rise   = ck_s2 && !ck_s3;
    ck_fall   = !ck_s2 && ck_s3;
    cs_rise   = cs_s2 && !cs_s3;
    lead_ev   = 1'b0;
    trail_ev  = 1'b0;
    xfer_done = 1'b0;
    if (mode) begin
      lead_ev   = tick && ph_next[0] && (ph_next <= two_n);
      trail_ev  = tick && !ph_next[0] && (ph_next <= two_n);
    end else begin
      lead_ev   = (state == XFER) && active && (cpol ? ck_fall : ck_rise);
      trail_ev  = (state == XFER) && active && (cpol ? ck_rise : ck_fall);
    end
    sample_ev = cpha ? trail_ev : lead_ev;
    shift_ev  = cpha ? lead_ev : trail_ev;
    if (mode)
      xfer_done = tick && (ph_next == two_n + 6'd2);
    else
      xfer_done = (state == XFER) &&
                  (cs_rise || (sample_ev && (bits + 5'd1 == nbits)));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= CFG;
      config_set   <= 1'b0;
      data_en      <= 1'b1;
      cfg          <= 8'd0;
      load_hi_done <= 1'b0;
      tx_sr        <= 16'd0;
      rx_sr        <= 16'd0;
      out_q        <= 1'b0;
      data_q       <= 8'd0;
      cs_q         <= 1'b1;
      clk_q        <= 1'b0;
      cs_oe        <= 1'b0;
      clk_oe       <= 1'b0;
      tmr          <= 4'd0;
      ph           <= 6'd0;
      bits         <= 5'd0;
      hold         <= 1'b0;
      cs_s1        <= 1'b1;
      cs_s2        <= 1'b1;
      cs_s3        <= 1'b1;
      ck_s1        <= 1'b0;
      ck_s2        <= 1'b0;
      ck_s3        <= 1'b0;
    end else begin
      cs_s1 <= cs;
      cs_s2 <= cs_s1;
      cs_s3 <= cs_s2;
      ck_s1 <= ext_clk;
      ck_s2 <= ck_s1;
      ck_s3 <= ck_s2;
      case (state)
        CFG: begin
          if (data[3:0] != 4'd0) begin
            cfg        <= data;
            config_set <= 1'b1;
            state      <= LOAD;
          end
        end
        LOAD: begin
          if (!load_hi_done) tx_sr[15:8] <= data;
          else               tx_sr[7:0]  <= data;
          if (len && !load_hi_done) begin
            load_hi_done <= 1'b1;
          end else begin
            state  <= XFER;
            out_q  <= load_hi_done ? tx_sr[15] : data[7];
            cs_oe  <= mode;
            clk_oe <= mode;
            cs_q   <= 1'b0;
            clk_q  <= cpol;
            tmr    <= 4'd0;
            ph     <= 6'd0;
            bits   <= 5'd0;
          end
        end
        XFER: begin
          if (mode) begin
            if (tick) begin
              tmr <= 4'd0;
              ph  <= ph_next;
            end else begin
              tmr <= tmr + 4'd1;
            end
            if (lead_ev || trail_ev) clk_q <= ~clk_q;
          end
          if (!mode && !active) out_q <= tx_sr[15];
          if (sample_ev) begin
            rx_sr <= {rx_sr[14:0], in};
            bits  <= bits + 5'd1;
          end
          // cpha=0 keeps out equal to the shift MSB; cpha=1 presents it on the leading edge.
          if (shift_ev) begin
            out_q <= cpha ? tx_sr[15] : tx_sr[14];
            tx_sr <= {tx_sr[14:0], 1'b0};
          end
          if (xfer_done) begin
            state <= DONE;
            cs_q  <= 1'b1;
            clk_q <= cpol;
          end
        end
        DONE: begin
          data_en <= 1'b0;
          hold    <= 1'b1;
          data_q  <= (len && !hold) ? rx_sr[15:8] : rx_sr[7:0];
        end
        default: state <= CFG;
      endcase
    end
  end

  assign out     = out_q;
  assign data    = data_en ? 8'bzzzz_zzzz : data_q;
  assign cs      = cs_oe ? cs_q : 1'bz;
  assign ext_clk = clk_oe ? clk_q : 1'bz;

endmodule

// File: tb/tb_spi_top.sv
// Bench for spi_top: acts as host, SPI follower (for leader frames) and SPI leader
// (for follower frames), checking against protocol-level expectations.
module tb_spi_top;

  logic       clk      = 1'b0;
  logic       rst      = 1'b1;
  logic       in_drv   = 1'b0;
  logic       loop     = 1'b0;
  logic [7:0] data_drv = 8'h00;
  logic       data_oe  = 1'b1;
  logic       cs_drv   = 1'b1;
  logic       ck_drv   = 1'b0;
  logic       bus_oe   = 1'b0;
  logic       watch    = 1'b0;
  logic       drove_seen = 1'b0;
  logic       out_w;
  logic       spi_in;
  wire  [7:0] data;
  wire        cs;
  wire        ext_clk;
  int         vectors = 0;
  int         errors  = 0;

  assign spi_in  = loop ? out_w : in_drv;
  assign data    = data_oe ? data_drv : 8'bzzzz_zzzz;
  assign cs      = bus_oe ? cs_drv : 1'bz;
  assign ext_clk = bus_oe ? ck_drv : 1'bz;

  spi_top dut (
    .clk     (clk),
    .rst     (rst),
    .in      (spi_in),
    .out     (out_w),
    .data    (data),
    .cs      (cs),
    .ext_clk (ext_clk)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (watch && (dut.cs_oe || dut.clk_oe)) drove_seen <= 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst      = 1'b1;
    data_oe  = 1'b1;
    data_drv = 8'h00;
    bus_oe   = 1'b0;
    loop     = 1'b0;
    in_drv   = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic load_cfg(input logic [7:0] c, input logic [15:0] tx);
    data_oe  = 1'b1;
    data_drv = c;
    @(negedge clk);
    data_drv = c[6] ? tx[15:8] : tx[7:0];
    @(negedge clk);
    if (c[6]) begin
      data_drv = tx[7:0];
      @(negedge clk);
    end
    data_oe = 1'b0;
  endtask

  // Bench plays the SPI follower: presents resp per cpha, captures MOSI at the follower's sample edge.
  task automatic leader_frame(input logic [7:0] c, input logic [15:0] tx,
                              input logic [15:0] resp, input logic lp);
    int n, dv, low, edges, ri, first_lead, second_lead, guard;
    logic prev_ck;
    logic [15:0] mosi, expd, mask;
    n     = c[6] ? 16 : 8;
    dv    = int'(c[3:0]);
    mask  = c[6] ? 16'hFFFF : 16'h00FF;
    expd  = (lp ? tx : resp) & mask;
    do_reset();
    loop = lp;
    load_cfg(c, tx);
    chk("lead_cs_fall", cs, 1'b0);
    chk("lead_ck_idle", ext_clk, c[5]);
    ri = n - 1;
    if (!c[4]) begin
      in_drv = resp[ri];
      ri--;
    end
    low = 0; edges = 0; first_lead = -1; second_lead = -1;
    prev_ck = c[5]; mosi = 16'h0; guard = 0;
    while (cs == 1'b0 && guard < 4000) begin
      low++;
      if (ext_clk != prev_ck) begin
        edges++;
        if (ext_clk != c[5]) begin
          if (first_lead < 0) first_lead = low;
          else if (second_lead < 0) second_lead = low;
          if (!c[4]) mosi = {mosi[14:0], out_w};
          else if (ri >= 0) begin in_drv = resp[ri]; ri--; end
        end else begin
          if (c[4]) mosi = {mosi[14:0], out_w};
          else if (ri >= 0) begin in_drv = resp[ri]; ri--; end
        end
        prev_ck = ext_clk;
      end
      @(negedge clk);
      guard++;
    end
    chk("lead_cs_rise", cs, 1'b1);
    chk("lead_cs_low", low, dv * (2 * n + 2));
    chk("lead_edges", edges, 2 * n);
    chk("lead_first_edge", first_lead - 1, dv);
    chk("lead_period", second_lead - first_lead, 2 * dv);
    chk("lead_mosi", mosi & mask, tx & mask);
    chk("lead_ck_end", ext_clk, c[5]);
    chk("lead_den_hold", dut.data_en, 1'b1);
    @(negedge clk);
    chk("lead_den_fall", dut.data_en, 1'b0);
    chk("lead_rx_first", data, (n == 16) ? expd[15:8] : expd[7:0]);
    if (n == 16) begin
      @(negedge clk);
      chk("lead_rx_lo", data, expd[7:0]);
      @(negedge clk);
      chk("lead_rx_hold", data, expd[7:0]);
    end
    chk("lead_cs_idle", cs, 1'b1);
  endtask

  // Bench plays the SPI leader with a 20-cycle sclk period.
  task automatic follower_frame(input logic [7:0] c, input logic [15:0] tx,
                                input logic [15:0] mosi_w);
    int n;
    logic [15:0] miso, mask;
    n    = c[6] ? 16 : 8;
    mask = c[6] ? 16'hFFFF : 16'h00FF;
    do_reset();
    bus_oe = 1'b1;
    cs_drv = 1'b1;
    ck_drv = c[5];
    drove_seen = 1'b0;
    watch  = 1'b1;
    load_cfg(c, tx);
    repeat (4) @(negedge clk);
    chk("fol_out_idle", out_w, (n == 16) ? tx[15] : tx[7]);
    miso   = 16'h0;
    cs_drv = 1'b0;
    if (!c[4]) in_drv = mosi_w[n-1];
    repeat (10) @(negedge clk);
    for (int i = n - 1; i >= 0; i--) begin
      ck_drv = ~c[5];
      if (!c[4]) miso = {miso[14:0], out_w};
      else       in_drv = mosi_w[i];
      repeat (10) @(negedge clk);
      ck_drv = c[5];
      if (c[4])       miso = {miso[14:0], out_w};
      else if (i > 0) in_drv = mosi_w[i-1];
      repeat (10) @(negedge clk);
    end
    cs_drv = 1'b1;
    repeat (4) @(negedge clk);
    watch = 1'b0;
    chk("fol_miso", miso & mask, tx & mask);
    chk("fol_no_drive", drove_seen, 1'b0);
    chk("fol_den", dut.data_en, 1'b0);
    chk("fol_rx", data, mosi_w[7:0]);
  endtask

  initial begin
    logic [7:0]  c;
    logic [15:0] tx, rw;
    logic        lp;

    do_reset();
    chk("rst_config_set", dut.config_set, 1'b0);
    chk("rst_data_en", dut.data_en, 1'b1);
    chk("rst_out", out_w, 1'b0);
    chk("rst_cs_oe", dut.cs_oe, 1'b0);
    chk("rst_ck_oe", dut.clk_oe, 1'b0);

    // Config guard: div field zero is ignored.
    do_reset();
    data_drv = 8'h80;
    repeat (5) @(negedge clk);
    chk("guard_config_set", dut.config_set, 1'b0);
    chk("guard_data_en", dut.data_en, 1'b1);
    chk("guard_cs_oe", dut.cs_oe, 1'b0);
    chk("guard_ck_oe", dut.clk_oe, 1'b0);
    chk("guard_out", out_w, 1'b0);
    data_drv = 8'h81;
    @(negedge clk);
    chk("guard_capture", dut.config_set, 1'b1);

    leader_frame(8'h82, 16'h00A5, 16'hFFFF, 1'b0);
    leader_frame(8'hB1, 16'h0000, 16'h003C, 1'b0);
    follower_frame(8'h01, 16'h005A, 16'h00C3);
    leader_frame(8'hC2, 16'h1234, 16'h0000, 1'b1);

    // Reset in the middle of bit 3 of a leader frame.
    do_reset();
    load_cfg(8'h82, 16'h00FF);
    repeat (14) @(negedge clk);
    chk("mid_cs_low", cs, 1'b0);
    chk("mid_out_before", out_w, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_cs_oe", dut.cs_oe, 1'b0);
    chk("mid_ck_oe", dut.clk_oe, 1'b0);
    chk("mid_data_en", dut.data_en, 1'b1);
    chk("mid_out", out_w, 1'b0);
    chk("mid_config_set", dut.config_set, 1'b0);
    chk("mid_state", dut.state, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      c[7]   = 1'b1;
      c[6]   = 1'($urandom_range(0, 1));
      c[5]   = 1'($urandom_range(0, 1));
      c[4]   = 1'($urandom_range(0, 1));
      c[3:0] = 4'($urandom_range(1, 3));
      tx     = 16'($urandom);
      rw     = 16'($urandom);
      lp     = 1'($urandom_range(0, 1));
      leader_frame(c, tx, rw, lp);
    end

    for (int i = 0; i < 4; i++) begin
      c[7]   = 1'b0;
      c[6]   = 1'($urandom_range(0, 1));
      c[5]   = 1'($urandom_range(0, 1));
      c[4]   = 1'($urandom_range(0, 1));
      c[3:0] = 4'($urandom_range(1, 15));
      tx     = 16'($urandom);
      rw     = 16'($urandom);
      follower_frame(c, tx, rw);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
